core_run_ctrl: RTL

//  Run sequencer for one RISC_V_Core. Takes a run command (program address and cycle budget).

---
 rtl/run_ctrl_pkg.sv | 30 +++
 rtl/run_cycle_counter.sv | 42 ++++
 rtl/core_run_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// run_ctrl_pkg : shared state encoding, status codes and parameter defaults
//                for the core run sequencer.
// Revision     : 1.0 - initial release
// ============================================================================
package run_ctrl_pkg;

    localparam int ADDRESS_BITS_DEF = 20;
    localparam int CYCLE_BITS_DEF   = 32;
    localparam int RESET_CYCLES_DEF = 2;
    localparam int START_CYCLES_DEF = 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RSTH   = 3'd1,
        S_START  = 3'd2,
        S_RUN    = 3'd3,
        S_REPORT = 3'd4,
        S_RESULT = 3'd5
    } run_state_e;

    typedef enum logic [1:0] {
        ST_DONE    = 2'b00,
        ST_TIMEOUT = 2'b01,
        ST_ABORT   = 2'b10
    } run_status_e;

endpackage
`default_nettype wire

// File: rtl/run_cycle_counter.sv
`default_nettype none
// ============================================================================
// run_cycle_counter : saturating up-counter with clear/enable and a
//                     terminal-value match flag.
// Revision          : 1.0 - initial release
// ============================================================================
module run_cycle_counter #(
    parameter int CYCLE_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_enable,
    input  logic [CYCLE_BITS-1:0] i_terminal,
    output logic [CYCLE_BITS-1:0] o_count,
    output logic                  o_match
);

    logic [CYCLE_BITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && (count_q != '1)) begin
            count_d = count_q + CYCLE_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_match = (count_q == i_terminal);

endmodule
`default_nettype wire

// File: rtl/core_run_ctrl.sv
`default_nettype none
// ============================================================================
// core_run_ctrl : run sequencer for one RISC-V core (reset, start, run, report).
//                 Budget timeout compiled in only with RUN_CTRL_TIMEOUT_EN.
// Revision      : 1.0 - initial release
// ============================================================================
module core_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int ADDRESS_BITS = ADDRESS_BITS_DEF,
    parameter int CYCLE_BITS   = CYCLE_BITS_DEF,
    parameter int RESET_CYCLES = RESET_CYCLES_DEF,
    parameter int START_CYCLES = START_CYCLES_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDRESS_BITS-1:0] cmd_prog_address,
    input  logic [CYCLE_BITS-1:0]   cmd_max_cycles,
    input  logic                    abort,
    input  logic                    core_done,
    output logic                    core_reset,
    output logic                    core_start,
    output logic [ADDRESS_BITS-1:0] core_prog_address,
    output logic                    core_report,
    output logic                    busy,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [CYCLE_BITS-1:0]   result_cycles,
    output logic [1:0]              result_status
);

    localparam logic [CYCLE_BITS-1:0] c_rsth_last  = CYCLE_BITS'(RESET_CYCLES - 1);
    localparam logic [CYCLE_BITS-1:0] c_start_last = CYCLE_BITS'(START_CYCLES - 1);

    run_state_e              state_q, state_d;
    run_status_e             status_q, status_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;

    logic                  w_cnt_clear;
    logic                  w_cnt_enable;
    logic                  w_cnt_match;
    logic [CYCLE_BITS-1:0] w_cnt_terminal;
    logic [CYCLE_BITS-1:0] w_cnt_value;
    logic [CYCLE_BITS-1:0] w_run_terminal;
    logic                  w_timeout_hit;
    logic                  w_accept;

    assign w_accept = (state_q == S_IDLE) && cmd_valid;

`ifdef RUN_CTRL_TIMEOUT_EN
    logic [CYCLE_BITS-1:0] max_q, max_d;

    always_comb begin
        max_d = max_q;
        if (w_accept) begin
            max_d = cmd_max_cycles;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    // Matching count == max-1 is the "count+1 == max" test; max == 0 means unlimited.
    assign w_run_terminal = max_q - CYCLE_BITS'(1);
    assign w_timeout_hit  = (max_q != '0) && w_cnt_match;
`else
    logic unused_max_cycles;
    assign unused_max_cycles = ^cmd_max_cycles;
    assign w_run_terminal    = '0;
    assign w_timeout_hit     = 1'b0;
`endif

    always_comb begin
        w_cnt_terminal = w_run_terminal;
        case (state_q)
            S_RSTH:  w_cnt_terminal = c_rsth_last;
            S_START: w_cnt_terminal = c_start_last;
            default: w_cnt_terminal = w_run_terminal;
        endcase
    end

    run_cycle_counter #(
        .CYCLE_BITS (CYCLE_BITS)
    ) u_counter (
        .clk        (clock),
        .rst_n      (reset),
        .i_clear    (w_cnt_clear),
        .i_enable   (w_cnt_enable),
        .i_terminal (w_cnt_terminal),
        .o_count    (w_cnt_value),
        .o_match    (w_cnt_match)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            status_q <= ST_DONE;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            addr_q   <= addr_d;
        end
    end

    // The counter keeps running on the RUN exit cycle so the result includes it,
    // then holds through REPORT/RESULT as the reported cycle count.
    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        addr_d       = addr_q;
        w_cnt_clear  = 1'b0;
        w_cnt_enable = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d     = S_RSTH;
                    addr_d      = cmd_prog_address;
                    w_cnt_clear = 1'b1;
                end
            end
            S_RSTH: begin
                if (abort) begin
                    state_d     = S_RESULT;
                    status_d    = ST_ABORT;
                    w_cnt_clear = 1'b1;
                end else if (w_cnt_match) begin
                    state_d     = S_START;
                    w_cnt_clear = 1'b1;
                end else begin
                    w_cnt_enable = 1'b1;
                end
            end
            S_START: begin
                if (abort) begin
                    state_d     = S_RESULT;
                    status_d    = ST_ABORT;
                    w_cnt_clear = 1'b1;
                end else if (w_cnt_match) begin
                    state_d     = S_RUN;
                    w_cnt_clear = 1'b1;
                end else begin
                    w_cnt_enable = 1'b1;
                end
            end
            S_RUN: begin
                w_cnt_enable = 1'b1;
                if (core_done) begin
                    state_d  = S_REPORT;
                    status_d = ST_DONE;
                end else if (w_timeout_hit) begin
                    state_d  = S_REPORT;
                    status_d = ST_TIMEOUT;
                end else if (abort) begin
                    state_d  = S_REPORT;
                    status_d = ST_ABORT;
                end
            end
            S_REPORT: state_d = S_RESULT;
            S_RESULT: begin
                if (result_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready         = (state_q == S_IDLE);
        core_reset        = (state_q == S_IDLE) || (state_q == S_RSTH);
        core_start        = (state_q == S_START);
        core_report       = (state_q == S_REPORT);
        busy              = (state_q != S_IDLE);
        result_valid      = (state_q == S_RESULT);
        result_cycles     = (state_q == S_RESULT) ? w_cnt_value : '0;
        result_status     = (state_q == S_RESULT) ? status_q : ST_DONE;
        core_prog_address = addr_q;
    end

endmodule
`default_nettype wire
